// File: rtl/oled_iic_writer_if.sv
// Request/status and I2C pin bundle between an OLED frame requester and
// the oled_iic_writer bus engine.
interface oled_iic_writer_if;
  logic        write_req;
  logic [23:0] write_data;
  logic        write_done;
  logic        busy;
  logic        ack_err;
  logic        iic_scl;
  logic        iic_sda_oe;
  logic        iic_sda_i;

  modport master (
    output write_req,
    output write_data,
    output iic_sda_i,
    input  write_done,
    input  busy,
    input  ack_err,
    input  iic_scl,
    input  iic_sda_oe
  );

  modport slave (
    input  write_req,
    input  write_data,
    input  iic_sda_i,
    output write_done,
    output busy,
    output ack_err,
    output iic_scl,
    output iic_sda_oe
  );
endinterface

// File: rtl/oled_iic_writer.sv
// Single-master I2C writer for an OLED controller: each accepted request sends
// one START, three bytes {addr, control, payload} with ACK slots, and one STOP.
module oled_iic_writer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 400_000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  oled_iic_writer_if.slave bus
);

  localparam int Q     = CLK_FREQ / (4 * IIC_FREQ);
  localparam int DIV_W = (Q > 2) ? $clog2(Q) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(Q - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [1:0]       q_r, q_s;
  logic [4:0]       bit_idx_r, bit_idx_s;
  logic [23:0]      shift_r, shift_s;
  logic             ack_err_r, ack_err_s;
  logic             scl_r, sda_oe_r;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic [1:0]       lv_s;
  logic             tick_s, slot_end_s;

  // Pin levels {scl, sda_oe} for a state, quarter phase and current data bit.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] q,
                                            input logic data_bit);
    logic [1:0] lv;
    case (st)
      ST_START: lv = {(q != 2'd3), q[1]};
      ST_DATA:  lv = {q[1], ~data_bit};
      ST_ACK:   lv = {q[1], 1'b0};
      ST_STOP:  lv = {(q != 2'd0), ~q[1]};
      default:  lv = {1'b1, 1'b0};
    endcase
    return lv;
  endfunction

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    q_s        = q_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    ack_err_s  = ack_err_r;
    tick_s     = (div_r == DIV_LAST);
    slot_end_s = tick_s && (q_r == 2'd3);

    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      div_s = '0;
      q_s   = 2'd0;
    end else if (tick_s) begin
      div_s = '0;
      q_s   = q_r + 2'd1;
    end else begin
      div_s = div_r + DIV_W'(1);
      q_s   = q_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.write_req) begin
          state_s   = ST_START;
          shift_s   = bus.write_data;
          bit_idx_s = 5'd23;
          ack_err_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (slot_end_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (slot_end_s) begin
          shift_s = {shift_r[22:0], 1'b0};
          if (bit_idx_r[2:0] == 3'd0) begin
            state_s = ST_ACK;
          end else begin
            bit_idx_s = bit_idx_r - 5'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_ACK: begin
        // A released (high) line at the end of q2 is a NACK; the frame carries on.
        if (tick_s && (q_r == 2'd2)) begin
          ack_err_s = ack_err_r | bus.iic_sda_i;
        end else begin
          ack_err_s = ack_err_r;
        end
        if (slot_end_s) begin
          if (bit_idx_r == 5'd0) begin
            state_s = ST_STOP;
          end else begin
            state_s   = ST_DATA;
            bit_idx_s = bit_idx_r - 5'd1;
          end
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_STOP: begin
        if (slot_end_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    lv_s   = bus_levels(state_s, q_s, shift_s[23]);
    done_s = (state_s == ST_DONE);
    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      div_r     <= '0;
      q_r       <= 2'd0;
      bit_idx_r <= 5'd0;
      shift_r   <= 24'd0;
      ack_err_r <= 1'b0;
      scl_r     <= 1'b1;
      sda_oe_r  <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      q_r       <= q_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      ack_err_r <= ack_err_s;
      scl_r     <= lv_s[1];
      sda_oe_r  <= lv_s[0];
      done_r    <= done_s;
      busy_r    <= busy_s;
    end
  end

  assign bus.iic_scl    = scl_r;
  assign bus.iic_sda_oe = sda_oe_r;
  assign bus.write_done = done_r;
  assign bus.busy       = busy_r;
  assign bus.ack_err    = ack_err_r;

endmodule

// File: tb/tb_oled_iic_writer.sv
// Directed/random bench for oled_iic_writer: an I2C bus monitor with an ACK/NACK
// slave, and frame-level expectations derived from the quarter period Q.
module tb_oled_iic_writer;
  localparam int CLK_FREQ = 50_000_000;
  localparam int IIC_FREQ = 400_000;
  localparam int Q        = CLK_FREQ / (4 * IIC_FREQ);
  localparam int DONE_REL = 116 * Q + 1;
  localparam int START_REL = 2 * Q + 1;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  oled_iic_writer_if bus();

  oled_iic_writer #(.CLK_FREQ(CLK_FREQ), .IIC_FREQ(IIC_FREQ)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Slave model: pulls SDA low during the ACK slot unless told to NACK that byte.
  logic       slave_low = 1'b0;
  logic [2:0] nack_mask = 3'b000;
  logic       mon_clr   = 1'b0;
  assign bus.iic_sda_i = ~(bus.iic_sda_oe | slave_low);

  // Monitor results (written only by the monitor process)
  int         done_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int         last_done_cyc = 0, last_start_cyc = 0;
  logic [7:0] cap_bytes[$];

  // Expectations (written only by the main sequence)
  int         exp_frames = 0;
  int         byte_base  = 0;
  logic       exp_ack_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor sampled on the falling clock edge
  initial begin : bus_monitor
    logic       prev_scl, prev_sda, scl_v, sda_v, in_frame;
    logic [7:0] cur_byte;
    int         bitcnt, last_rise, last_fall;
    prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0;
    cur_byte = 8'h00; bitcnt = 0; last_rise = 0; last_fall = 0;
    forever begin
      @(negedge sys_clk);
      scl_v = bus.iic_scl;
      sda_v = bus.iic_sda_i;
      if (mon_clr) begin
        done_cnt = 0; start_cnt = 0; stop_cnt = 0; bitcnt = 0;
        in_frame = 1'b0; slave_low = 1'b0; cap_bytes.delete();
      end else begin
        if (bus.write_done === 1'b1) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (prev_scl && scl_v && prev_sda && !sda_v) begin
          start_cnt++;
          last_start_cyc = cyc;
          bitcnt = 0;
          in_frame = 1'b1;
        end else if (prev_scl && scl_v && !prev_sda && sda_v) begin
          stop_cnt++;
          in_frame = 1'b0;
        end else if (in_frame && !prev_scl && scl_v) begin
          if (bitcnt >= 1 && bitcnt <= 26) check("scl_low_time", cyc - last_fall, 2 * Q);
          if (bitcnt % 9 < 8) cur_byte = {cur_byte[6:0], sda_v};
          if (bitcnt % 9 == 7) cap_bytes.push_back(cur_byte);
          bitcnt++;
          last_rise = cyc;
        end else if (in_frame && prev_scl && !scl_v) begin
          if (bitcnt > 0) check("scl_high_time", cyc - last_rise, 2 * Q);
          last_fall = cyc;
          slave_low = (bitcnt > 0 && bitcnt % 9 == 8) ? ~nack_mask[bitcnt / 9] : 1'b0;
        end
      end
      prev_scl = scl_v;
      prev_sda = sda_v;
    end
  end

  // One frame: request at cycle 0, optional hold of write_req, full frame-level checks.
  task automatic send_frame(input logic [23:0] data, input logic [2:0] nacks, input bit keep_req);
    int t0;
    @(negedge sys_clk);
    check("gap_busy", bus.busy, 1'b0);
    check("ack_err_sticky", bus.ack_err, exp_ack_err);
    nack_mask      = nacks;
    bus.write_req  = 1'b1;
    bus.write_data = data;
    t0 = cyc;
    @(negedge sys_clk);
    if (!keep_req) bus.write_req = 1'b0;
    bus.write_data = 24'($urandom);
    check("busy_after_accept", bus.busy, 1'b1);
    check("ack_err_cleared", bus.ack_err, 1'b0);
    repeat (DONE_REL - 1) @(negedge sys_clk);
    check("write_done_pulse", bus.write_done, 1'b1);
    check("busy_in_done", bus.busy, 1'b1);
    exp_ack_err = |nacks;
    check("ack_err_result", bus.ack_err, exp_ack_err);
    #1;
    exp_frames++;
    check("done_count", done_cnt, exp_frames);
    check("done_cycle", last_done_cyc - t0, DONE_REL);
    check("start_count", start_cnt, exp_frames);
    check("start_cycle", last_start_cyc - t0, START_REL);
    check("stop_count", stop_cnt, exp_frames);
    check("byte_count", cap_bytes.size() - byte_base, 3);
    if (cap_bytes.size() >= byte_base + 3) begin
      for (int b = 0; b < 3; b++) check("sda_byte", cap_bytes[byte_base + b], data[23 - 8 * b -: 8]);
    end
    byte_base = cap_bytes.size();
  endtask

  initial begin : main_seq
    logic [23:0] rdata;
    bus.write_req  = 1'b0;
    bus.write_data = 24'd0;
    mon_clr        = 1'b1;
    repeat (4) @(negedge sys_clk);
    rst_n   = 1'b1;
    mon_clr = 1'b0;
    @(negedge sys_clk);
    check("rst_scl", bus.iic_scl, 1'b1);
    check("rst_sda_oe", bus.iic_sda_oe, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.write_done, 1'b0);
    check("rst_ack_err", bus.ack_err, 1'b0);

    // Pulsed request, all bytes ACKed
    send_frame(24'h78_00_AF, 3'b000, 1'b0);
    repeat (3) @(negedge sys_clk);

    // Second byte NACKed: flag set, held through idle, cleared by next acceptance
    rdata = 24'($urandom);
    send_frame(rdata, 3'b010, 1'b0);
    repeat (6) @(negedge sys_clk);
    check("ack_err_held_idle", bus.ack_err, 1'b1);

    // write_req held high: back-to-back frames one IDLE cycle apart
    for (int i = 0; i < 3; i++) begin
      rdata = {16'h78_40, 8'($urandom)};
      send_frame(rdata, 3'b000, 1'b1);
    end
    @(negedge sys_clk);
    bus.write_req = 1'b0;
    check("held_idle_busy", bus.busy, 1'b0);

    // Random payloads with random ACK/NACK patterns
    for (int i = 0; i < 3; i++) begin
      rdata = 24'($urandom);
      send_frame(rdata, 3'($urandom_range(0, 7)), 1'b0);
      repeat (2) @(negedge sys_clk);
    end

    // Reset in the middle of byte 2 while SCL is low
    @(negedge sys_clk);
    check("pre_abort_ack_err", bus.ack_err, exp_ack_err);
    nack_mask      = 3'b000;
    bus.write_data = 24'($urandom);
    bus.write_req  = 1'b1;
    @(negedge sys_clk);
    bus.write_req = 1'b0;
    repeat (48 * Q + 2) @(negedge sys_clk);
    rst_n   = 1'b0;
    mon_clr = 1'b1;
    @(negedge sys_clk);
    rst_n = 1'b1;
    check("abort_scl", bus.iic_scl, 1'b1);
    check("abort_sda_oe", bus.iic_sda_oe, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.write_done, 1'b0);
    check("abort_ack_err", bus.ack_err, 1'b0);
    @(negedge sys_clk);
    mon_clr     = 1'b0;
    exp_frames  = 0;
    byte_base   = 0;
    exp_ack_err = 1'b0;
    repeat (DONE_REL) @(negedge sys_clk);
    check("no_done_after_abort", done_cnt, 0);
    check("no_stop_after_abort", stop_cnt, 0);
    check("idle_scl_after_abort", bus.iic_scl, 1'b1);
    rdata = 24'($urandom);
    send_frame(rdata, 3'b000, 1'b0);
    repeat (4) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_iic_writer.md
OLED_IIC_WRITER -- requirements
Module: oled_iic_writer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the sys_clk frequency in Hz.
REQ-002 SHALL have parameter IIC_FREQ, default 400_000, meaning the target SCL frequency in Hz.
REQ-003 SHALL have port sys_clk  in  1  system clock; all logic runs on the rising edge of this one clock.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port write_req  in  1  level request; the requester holds it high while frames remain to be sent.
REQ-006 SHALL have port write_data  in  24  frame {slave addr byte, control byte, payload byte}, sent MSB first.
REQ-007 SHALL have port write_done  out  1  single-cycle pulse marking that the current frame has completed, including STOP.
REQ-008 SHALL have port busy  out  1  high from frame acceptance through the write_done cycle.
REQ-009 SHALL have port ack_err  out  1  sticky flag: a NACK was seen in the current or most recent frame.
REQ-010 SHALL have port iic_scl  out  1  SCL, driven push-pull.
REQ-011 SHALL have port iic_sda_oe  out  1  1 = pull SDA low, 0 = release SDA to the external pull-up.
REQ-012 SHALL have port iic_sda_i  in  1  sampled SDA line level.

Function
REQ-013 SHALL define the quarter-bit period Q = CLK_FREQ/(4*IIC_FREQ) using integer division; Q = 31 at the defaults; Q < 2 is an illegal configuration.
REQ-014 SHALL use a divider that restarts at 0 on frame acceptance and issues a one-cycle tick when it reaches Q-1, then wraps to 0.
REQ-015 SHALL implement states IDLE, START, DATA, ACK, STOP, DONE, with phase counter q (0..3) advanced on each tick.
REQ-016 In IDLE, SHALL hold iic_scl=1, iic_sda_oe=0 and busy=0.
REQ-017 SHALL accept a frame when write_req=1 in IDLE; at acceptance, latch write_data into a shift register, clear ack_err, and go to START.
REQ-018 START timing: SDA released in q0-q1, SDA pulled low in q2, SCL low in q3; then go to DATA at bit 23.
REQ-019 DATA bit timing: SCL low in q0-q1 and high in q2-q3; SDA is set at the start of q0 (oe = ~bit) and held constant while SCL is high.
REQ-020 After 8 bits, SHALL enter ACK: SDA released, same SCL timing, iic_sda_i sampled on the tick that ends q2.
REQ-021 A sampled 1 in ACK SHALL set ack_err; the frame SHALL continue regardless (no retry, no abort).
REQ-022 After the ACKs of bytes 1 and 2, SHALL return to DATA for the next byte; after the ACK of byte 3, SHALL go to STOP.
REQ-023 STOP timing: SCL low with SDA pulled low in q0, SCL high in q1, SDA released in q2-q3; then go to DONE.
REQ-024 Frame length SHALL be 29 bit slots x 4 quarters = 116 ticks (START + 27 data/ACK slots + STOP).
REQ-025 With the acceptance cycle counted as cycle 0, write_done SHALL be high only in cycle 116*Q+1 (3597 at the defaults), in DONE.
REQ-026 DONE SHALL last exactly one cycle and then go to IDLE; write_req is not sampled in DONE.
REQ-027 Minimum frame-to-frame spacing SHALL be one IDLE cycle, so the next acceptance occurs no earlier than cycle 116*Q+2.
REQ-028 write_data SHALL be read only at acceptance; changes during a frame have no effect.
REQ-029 write_req falling mid-frame SHALL NOT abort the frame; write_done is still issued.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 While rst_n=0 at a clock edge, SHALL next hold: state=IDLE, iic_scl=1, iic_sda_oe=0, write_done=0, busy=0, ack_err=0, divider=0, q=0, shift register=0.
REQ-032 A reset asserted mid-frame SHALL abandon the frame immediately, with no STOP and no write_done; the first frame after reset starts with a fresh START.

Verification
REQ-033 Defaults, write_req pulsed with data 24'h78_00_AF, slave model ACKs every byte -> SDA bytes captured on SCL rising edges are 78, 00, AF; exactly one write_done, at cycle 3597; ack_err=0.
REQ-034 write_req held high, data 24'h78_40_xx updated the cycle after each write_done -> three back-to-back frames, accept-to-accept spacing 3598 cycles, each with a correct START and STOP.
REQ-035 Slave NACKs the second byte -> frame completes, write_done at cycle 3597, ack_err=1 and held until the next acceptance clears it.
REQ-036 rst_n driven low for one cycle during byte 2 -> next cycle iic_scl=1, iic_sda_oe=0, busy=0; no write_done; the next request produces a complete, correct frame.
REQ-037 Protocol checker on every frame -> SDA changes only while SCL is low, except the START and STOP edges; SCL high/low time is 2*Q cycles each.
